// File: rtl/inv_round_tf_if.sv
// Handshake and data bundle for the AES inverse round transform.
// The controller side uses the master modport, the transform uses slave.
interface inv_round_tf_if;
  logic         start;
  logic [127:0] b_i;
  logic [127:0] b_imc_o;
  logic [127:0] b_isr_o;
  logic [127:0] b_o;
  logic         busy_o;
  logic         done_o;

  modport master (
    output start, b_i,
    input  b_imc_o, b_isr_o, b_o, busy_o, done_o
  );

  modport slave (
    input  start, b_i,
    output b_imc_o, b_isr_o, b_o, busy_o, done_o
  );
endinterface

// File: rtl/inv_round_tf.sv
// AES inverse round transform: InvMixColumns (optional), InvShiftRows,
// then InvSubBytes applied BPC bytes per cycle over N = 16/BPC cycles.
// AddRoundKey is left to the round controller.
module inv_round_tf #(
  parameter int EN_IMC = 1,
  parameter int BPC    = 4
) (
  input  logic         clk,
  input  logic         rst,
  inv_round_tf_if.slave bus
);

  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [127:0]  cap;
  logic [127:0]  work;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;

  logic [127:0]  imc;
  logic [127:0]  isr;
  logic [127:0]  in_imc;
  logic [127:0]  in_isr;
  logic [127:0]  work_nxt;

  // GF(2^8) multiply by x, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) general multiply (shift-and-add).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // One column through the {0e,0b,0d,09} circulant.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
            gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
            gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
            gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r rotates right by r: out[r+4c] = in[r+4((c-r) mod 4)].
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  // Linear front end for both the trace outputs (from cap) and the capture path (from b_i).
  always_comb begin
    if (EN_IMC != 0) begin
      imc    = inv_mix(cap);
      in_imc = inv_mix(bus.b_i);
    end else begin
      imc    = cap;
      in_imc = bus.b_i;
    end
    isr    = inv_shift(imc);
    in_isr = inv_shift(in_imc);
  end

  // Substitute the chunk selected by cnt; other bytes pass through.
  always_comb begin
    work_nxt = work;
    for (int c = 0; c < N; c++) begin
      if (cnt == CW'(c)) begin
        for (int j = 0; j < BPC; j++)
          work_nxt[127-8*(c*BPC+j) -: 8] = inv_sbox(work[127-8*(c*BPC+j) -: 8]);
      end else begin
        work_nxt = work_nxt;
      end
    end
  end

  // Control FSM, capture and work registers; DONE accepts start like IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cap   <= 128'h0;
      work  <= 128'h0;
      cnt   <= {CW{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            cap   <= bus.b_i;
            work  <= in_isr;
            cnt   <= {CW{1'b0}};
            busy  <= 1'b1;
            state <= ST_SUB;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SUB: begin
          work <= work_nxt;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.b_imc_o = imc;
  assign bus.b_isr_o = isr;
  assign bus.b_o     = work;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done;

endmodule

// File: tb/tb_inv_round_tf.sv
// Bench for inv_round_tf: four instances (EN_IMC/BPC = 1/4, 0/4, 1/1, 1/16)
// checked every cycle against a transaction-level model, plus known vectors
// and random round trips through a forward AES round.
module tb_inv_round_tf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_v [4];
  logic [127:0] bi_v    [4];
  logic [127:0] bo_v    [4];
  logic [127:0] imc_v   [4];
  logic [127:0] isr_v   [4];
  logic         busy_v  [4];
  logic         done_v  [4];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int EN = (gi == 1) ? 0 : 1;
    localparam int BP = (gi == 2) ? 1 : ((gi == 3) ? 16 : 4);
    inv_round_tf_if bus ();
    assign bus.start  = start_v[gi];
    assign bus.b_i    = bi_v[gi];
    assign bo_v[gi]   = bus.b_o;
    assign imc_v[gi]  = bus.b_imc_o;
    assign isr_v[gi]  = bus.b_isr_o;
    assign busy_v[gi] = bus.busy_o;
    assign done_v[gi] = bus.done_o;
    inv_round_tf #(.EN_IMC(EN), .BPC(BP)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  end

  function automatic int lane_en(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic int lane_bpc(input int i);
    return (i == 2) ? 1 : ((i == 3) ? 16 : 4);
  endfunction

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  // dir=+1 forward ShiftRows, dir=-1 inverse.
  function automatic logic [127:0] shift(input logic [127:0] s, input int dir);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + dir*r + 8) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] m);
    logic [127:0] o;
    logic [7:0]   acc;
    logic [7:0]   mm [4];
    mm[0] = m[31:24]; mm[1] = m[23:16]; mm[2] = m[15:8]; mm[3] = m[7:0];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(mm[(j - r + 4) % 4], gb(s, 4*c + j));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] x, input int en);
    logic [127:0] s;
    for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sb[gb(x, k)];
    s = shift(s, 1);
    if (en != 0) s = mix(s, 32'h02030101);
    return s;
  endfunction

  function automatic logic [127:0] m_imc(input int i, input logic [127:0] cap);
    return (lane_en(i) != 0) ? mix(cap, 32'h0e0b0d09) : cap;
  endfunction

  // State after k chunks of substitution on lane i.
  function automatic logic [127:0] partial(input int i, input logic [127:0] cap, input int k);
    logic [127:0] s;
    s = shift(m_imc(i, cap), -1);
    for (int j = 0; j < k * lane_bpc(i); j++) s[127-8*j -: 8] = isb[gb(s, j)];
    return s;
  endfunction

  task automatic chk(input string nm, input int ln, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d got=%h want=%h", nm, ln, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  logic [127:0] m_cap  [4];
  logic [127:0] m_bo   [4];
  int           m_k    [4];
  bit           m_busy [4];
  bit           m_done [4];

  // Model: capture when not busy, one chunk per edge, done after N chunks.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_k[i] <= 0;
        m_cap[i]  <= '0;   m_bo[i]   <= '0;
      end else if (!m_busy[i] && start_v[i]) begin
        m_cap[i]  <= bi_v[i];
        m_k[i]    <= 0;
        m_busy[i] <= 1'b1;
        m_done[i] <= 1'b0;
        m_bo[i]   <= partial(i, bi_v[i], 0);
      end else if (m_busy[i]) begin
        m_k[i]    <= m_k[i] + 1;
        m_bo[i]   <= partial(i, m_cap[i], m_k[i] + 1);
        m_done[i] <= (m_k[i] + 1 == 16 / lane_bpc(i));
        m_busy[i] <= (m_k[i] + 1 != 16 / lane_bpc(i));
      end else begin
        m_done[i] <= 1'b0;
      end
    end
  end

  // Compare every lane's outputs against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        chk("busy", i, 128'(busy_v[i]), 128'(m_busy[i]));
        chk("done", i, 128'(done_v[i]), 128'(m_done[i]));
        chk("b_o", i, bo_v[i], m_bo[i]);
        chk("b_imc", i, imc_v[i], m_imc(i, m_cap[i]));
        chk("b_isr", i, isr_v[i], shift(m_imc(i, m_cap[i]), -1));
      end
    end
  end

  // Issue one start on a lane (called just after a falling edge); wait for done.
  task automatic op(input int ln, input logic [127:0] d, output logic [127:0] res,
                    output int lat, output int nbusy);
    bit seen;
    seen = 1'b0; res = '0; lat = -1; nbusy = 0;
    start_v[ln] = 1'b1; bi_v[ln] = d;
    @(negedge clk);
    start_v[ln] = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (done_v[ln]) begin
        seen = 1'b1; res = bo_v[ln]; lat = t;
      end else begin
        if (busy_v[ln]) nbusy++;
        @(negedge clk);
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout lane%0d got=none want=done_o", ln);
    end
  endtask

  localparam logic [127:0] T3_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] T3_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  initial begin
    logic [127:0] res, x, v;
    int lat, nb, cnt;
    logic [7:0] inv;

    // Build forward/inverse S-box from the GF inverse and affine map.
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
      sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);

    // Pin the reference model to known values.
    chk("pin_isb00", 0, 128'(isb[0]), 128'h52);
    chk("pin_isb63", 0, 128'(isb[8'h63]), 128'h00);
    chk("pin_sb19", 0, 128'(sb[8'h19]), 128'hd4);
    v = mix({32'h8e4da1bc, 96'h0}, 32'h0e0b0d09);
    chk("pin_imc_col", 0, 128'(v[127:96]), 128'hdb135345);
    chk("pin_model_t3", 0, partial(0, T3_IN, 4), T3_OUT);

    for (int i = 0; i < 4; i++) begin start_v[i] = 1'b0; bi_v[i] = '0; end
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_b_o", i, bo_v[i], 128'h0);
      chk("rst_busy", i, 128'(busy_v[i]), 128'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Zero state and FIPS-197 round on BPC = 4, 1, 16.
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        op(i, 128'h0, res, lat, nb);
        chk("t1_b_o", i, res, {16{8'h52}});
        chk("t1_latency", i, 128'(lat), 128'(16 / lane_bpc(i)));
        chk("t1_busy_cycles", i, 128'(nb), 128'(16 / lane_bpc(i)));
        op(i, T3_IN, res, lat, nb);
        chk("t3_b_o", i, res, T3_OUT);
      end
    end

    // Uniform 0x63 state.
    op(0, {16{8'h63}}, res, lat, nb);
    chk("t2_b_o", 0, res, 128'h0);
    chk("t2_b_imc", 0, imc_v[0], {16{8'h63}});

    // Bypass lane.
    op(1, T3_IN, res, lat, nb);
    chk("t4_b_imc", 1, imc_v[1], T3_IN);
    chk("t4_b_o", 1, res, partial(1, T3_IN, 4));

    // start held through SUB: one done, first data kept.
    start_v[0] = 1'b1; bi_v[0] = T3_IN;
    @(negedge clk);
    bi_v[0] = 128'h0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    cnt = 0; x = '0;
    for (int t = 0; t < 12; t++) begin
      if (done_v[0]) begin cnt++; x = bo_v[0]; end
      @(negedge clk);
    end
    chk("t5_done_count", 0, 128'(cnt), 128'd1);
    chk("t5_b_o", 0, x, T3_OUT);

    // Back-to-back: second start in the done cycle.
    op(0, 128'h0, res, lat, nb);
    op(0, T3_IN, res, lat, nb);
    chk("t5_b2b_latency", 0, 128'(lat), 128'd4);
    chk("t5_b2b_b_o", 0, res, T3_OUT);

    // Reset in the middle of SUB.
    start_v[0] = 1'b1; bi_v[0] = T3_IN;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_b_o", 0, bo_v[0], 128'h0);
    chk("t6_b_imc", 0, imc_v[0], 128'h0);
    chk("t6_busy", 0, 128'(busy_v[0]), 128'h0);
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      if (done_v[0]) cnt++;
      @(negedge clk);
    end
    chk("t6_no_done", 0, 128'(cnt), 128'd0);
    op(0, T3_IN, res, lat, nb);
    chk("t6_after_b_o", 0, res, T3_OUT);

    // Random round trips through the forward round.
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < ((i < 2) ? 5000 : 150); n++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        op(i, fwd(x, lane_en(i)), res, lat, nb);
        chk("rand_roundtrip", i, res, x);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
